// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 icodes, register IDs, status codes and the D-register layout
package y86_pkg;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;
  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } d_reg_t;
  localparam d_reg_t D_NOP = '{stat: S_AOK, icode: I_NOP, ifun: 4'h0, ra: RNONE, rb: RNONE, valc: 64'd0, valp: 64'd0};
endpackage

// File: rtl/decode_stage_reg_file.sv
// reg_file: 15x64 register file, two async read ports, two sync write ports (M port wins on collision)
module reg_file
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] val_a,
  output logic [63:0] val_b,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m
);
  logic [63:0] regs [15];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) regs[i] <= (4'(i) == RRSP) ? RSP_INIT : 64'd0;
    end else begin
      if (dst_e != RNONE) regs[dst_e] <= val_e;
      if (dst_m != RNONE) regs[dst_m] <= val_m;
    end
  end
  assign val_a = (src_a == RNONE) ? 64'd0 : regs[src_a];
  assign val_b = (src_b == RNONE) ? 64'd0 : regs[src_b];
endmodule

// File: rtl/decode_stage.sv
// decode_stage: Y86-64 D pipeline register, register file and operand forwarding
module decode_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  f_stat,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstE,
  input  logic [63:0] M_valE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] m_valM,
  input  logic [3:0]  W_dstE,
  input  logic [63:0] W_valE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valM,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [63:0] D_valC,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [3:0]  d_dstE,
  output logic [3:0]  d_dstM,
  output logic [63:0] d_valA,
  output logic [63:0] d_valB
);
  d_reg_t d_q;
  logic [63:0] rf_a, rf_b;
  always_ff @(posedge clk) begin
    if (rst || D_bubble) d_q <= D_NOP;
    else if (!D_stall) d_q <= '{stat: f_stat, icode: f_icode, ifun: f_ifun, ra: f_rA, rb: f_rB, valc: f_valC, valp: f_valP};
  end
  assign D_stat  = d_q.stat;
  assign D_icode = d_q.icode;
  assign D_ifun  = d_q.ifun;
  assign D_valC  = d_q.valc;
  always_comb begin
    d_srcA = (d_q.icode inside {I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ}) ? d_q.ra :
             (d_q.icode inside {I_RET, I_POPQ}) ? RRSP : RNONE;
    d_srcB = (d_q.icode inside {I_RMMOVQ, I_MRMOVQ, I_OPQ}) ? d_q.rb :
             (d_q.icode inside {I_CALL, I_RET, I_PUSHQ, I_POPQ}) ? RRSP : RNONE;
    d_dstE = (d_q.icode inside {I_RRMOVQ, I_IRMOVQ, I_OPQ}) ? d_q.rb :
             (d_q.icode inside {I_CALL, I_RET, I_PUSHQ, I_POPQ}) ? RRSP : RNONE;
    d_dstM = (d_q.icode inside {I_MRMOVQ, I_POPQ}) ? d_q.ra : RNONE;
  end
  // Youngest producer wins; jXX/call carry valP down the pipe in the valA slot
  always_comb begin
    d_valA = (d_q.icode inside {I_JXX, I_CALL}) ? d_q.valp :
             (d_srcA == RNONE)  ? 64'd0  :
             (d_srcA == e_dstE) ? e_valE :
             (d_srcA == M_dstM) ? m_valM :
             (d_srcA == M_dstE) ? M_valE :
             (d_srcA == W_dstM) ? W_valM :
             (d_srcA == W_dstE) ? W_valE : rf_a;
    d_valB = (d_srcB == RNONE)  ? 64'd0  :
             (d_srcB == e_dstE) ? e_valE :
             (d_srcB == M_dstM) ? m_valM :
             (d_srcB == M_dstE) ? M_valE :
             (d_srcB == W_dstM) ? W_valM :
             (d_srcB == W_dstE) ? W_valE : rf_b;
  end
  reg_file #(.RSP_INIT(RSP_INIT)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .src_a (d_srcA),
    .src_b (d_srcB),
    .val_a (rf_a),
    .val_b (rf_b),
    .dst_e (W_dstE),
    .val_e (W_valE),
    .dst_m (W_dstM),
    .val_m (W_valM)
  );
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed plus random stimulus against a table-driven decode reference model
module tb_decode_stage;
  localparam logic [63:0] RSP_INIT = 64'hF000;
  logic clk = 0;
  logic rst = 1;
  logic [2:0] f_stat = 1;
  logic [3:0] f_icode = 1, f_ifun = 0, f_rA = 15, f_rB = 15;
  logic [63:0] f_valC = 0, f_valP = 0;
  logic D_stall = 0, D_bubble = 0;
  logic [3:0] e_dstE = 15, M_dstE = 15, M_dstM = 15, W_dstE = 15, W_dstM = 15;
  logic [63:0] e_valE = 0, M_valE = 0, m_valM = 0, W_valE = 0, W_valM = 0;
  logic [2:0] D_stat;
  logic [3:0] D_icode, D_ifun, d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] D_valC, d_valA, d_valB;
  int errors = 0, checks = 0;
  logic [63:0] mrf [15];
  logic [2:0] m_stat;
  logic [3:0] m_icode, m_ifun, m_ra, m_rb;
  logic [63:0] m_valc, m_valp;

  decode_stage #(.RSP_INIT(RSP_INIT)) dut (
    .clk(clk), .rst(rst), .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun),
    .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
    .D_stall(D_stall), .D_bubble(D_bubble), .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_valC(D_valC),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_valA(d_valA), .d_valB(d_valB)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Per-icode register usage table: {srcA, srcB, dstE, dstM}
  function automatic logic [15:0] ids();
    logic [3:0] a, b, e, m;
    a = 15; b = 15; e = 15; m = 15;
    case (m_icode)
      2:  begin a = m_ra; e = m_rb; end
      3:  e = m_rb;
      4:  begin a = m_ra; b = m_rb; end
      5:  begin b = m_rb; m = m_ra; end
      6:  begin a = m_ra; b = m_rb; e = m_rb; end
      8:  begin b = 4; e = 4; end
      9:  begin a = 4; b = 4; e = 4; end
      10: begin a = m_ra; b = 4; e = 4; end
      11: begin a = 4; b = 4; e = 4; m = m_ra; end
      default: ;
    endcase
    return {a, b, e, m};
  endfunction

  function automatic logic [63:0] operand(input logic [3:0] src);
    logic [3:0] who [5];
    logic [63:0] val [5];
    who = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    val = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    if (src == 15) return 0;
    for (int k = 0; k < 5; k++) if (who[k] == src) return val[k];
    return mrf[src];
  endfunction

  task automatic check_all();
    logic [15:0] r;
    r = ids();
    check("D_stat", 64'(D_stat), 64'(m_stat));
    check("D_icode", 64'(D_icode), 64'(m_icode));
    check("D_ifun", 64'(D_ifun), 64'(m_ifun));
    check("D_valC", D_valC, m_valc);
    check("d_srcA", 64'(d_srcA), 64'(r[15:12]));
    check("d_srcB", 64'(d_srcB), 64'(r[11:8]));
    check("d_dstE", 64'(d_dstE), 64'(r[7:4]));
    check("d_dstM", 64'(d_dstM), 64'(r[3:0]));
    check("d_valA", d_valA, (m_icode == 7 || m_icode == 8) ? m_valp : operand(r[15:12]));
    check("d_valB", d_valB, operand(r[11:8]));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 15; k++) mrf[k] = (k == 4) ? RSP_INIT : 64'd0;
    end else begin
      if (W_dstE != 15) mrf[W_dstE] = W_valE;
      if (W_dstM != 15) mrf[W_dstM] = W_valM;
    end
    if (D_bubble && D_stall && !rst) $display("protocol warning: bubble and stall both asserted");
    if (rst || D_bubble) begin
      m_stat = 1; m_icode = 1; m_ifun = 0; m_ra = 15; m_rb = 15; m_valc = 0; m_valp = 0;
    end else if (!D_stall) begin
      m_stat = f_stat; m_icode = f_icode; m_ifun = f_ifun; m_ra = f_rA; m_rb = f_rB;
      m_valc = f_valC; m_valp = f_valP;
    end
    #1 check_all();
  endtask

  task automatic no_fwd();
    e_dstE = 15; M_dstE = 15; M_dstM = 15; W_dstE = 15; W_dstM = 15;
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vp);
    f_stat = 1; f_icode = ic; f_ifun = 0; f_rA = ra; f_rB = rb; f_valC = {$urandom, $urandom}; f_valP = vp;
  endtask

  function automatic logic [3:0] rid();
    return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
  endfunction

  initial begin
    tick();
    rst = 0;
    tick();
    check("reset_icode", 64'(D_icode), 1);
    check("reset_srcA", 64'(d_srcA), 15);
    check("reset_valB", d_valB, 0);
    W_dstE = 2; W_valE = 64'h55;
    tick();
    no_fwd();
    fetch(6, 2, 3, 0);
    tick();
    check("opq_valA_rf", d_valA, 64'h55);
    check("opq_dstE", 64'(d_dstE), 3);
    fetch(6, 1, 3, 0);
    tick();
    e_dstE = 1; e_valE = 64'hA; M_dstE = 1; M_valE = 64'hB; W_dstE = 1; W_valE = 64'hC;
    #1 check_all();
    check("fwd_e", d_valA, 64'hA);
    e_dstE = 15;
    #1 check_all();
    check("fwd_M", d_valA, 64'hB);
    no_fwd();
    fetch(8, 15, 15, 64'h20);
    tick();
    check("call_valA", d_valA, 64'h20);
    check("call_srcB", 64'(d_srcB), 4);
    fetch(9, 15, 15, 64'h30);
    tick();
    check("ret_valA", d_valA, RSP_INIT);
    D_stall = 1;
    fetch(3, 5, 6, 64'h40);
    tick();
    fetch(5, 7, 8, 64'h48);
    tick();
    check("stall_hold", 64'(D_icode), 9);
    D_stall = 0; D_bubble = 1;
    tick();
    D_bubble = 0;
    check("bubble_icode", 64'(D_icode), 1);
    W_dstE = 4; W_valE = 64'h10; W_dstM = 4; W_valM = 64'h99;
    fetch(9, 15, 15, 0);
    tick();
    no_fwd();
    fetch(9, 15, 15, 0);
    tick();
    check("popq_rsp_m_wins", d_valA, 64'h99);
    D_stall = 1; D_bubble = 1;
    tick();
    D_stall = 0; D_bubble = 0;
    rst = 1; W_dstE = 3; W_valE = 64'h77; W_dstM = 4; W_valM = 64'h88;
    tick();
    rst = 0; no_fwd();
    fetch(4, 3, 4, 0);
    tick();
    check("rst_over_write_r3", d_valA, 0);
    check("rst_over_write_rsp", d_valB, RSP_INIT);
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      D_bubble = ($urandom_range(0, 15) == 0);
      D_stall = !D_bubble && ($urandom_range(0, 7) == 0);
      f_stat = 3'($urandom_range(1, 4));
      f_icode = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
      f_ifun = 4'($urandom); f_rA = rid(); f_rB = rid();
      f_valC = {$urandom, $urandom}; f_valP = {$urandom, $urandom};
      e_dstE = rid(); M_dstE = rid(); M_dstM = rid(); W_dstE = rid(); W_dstM = rid();
      e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom}; m_valM = {$urandom, $urandom};
      W_valE = {$urandom, $urandom}; W_valM = {$urandom, $urandom};
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
